// File: rtl/sram_arbiter.sv
// Round-robin arbiter and strobe sequencer sharing one 256K x 16 asynchronous SRAM
// between the logger (port 0) and telemetry (port 1); the D pad tristate lives one level up.
module sram_arbiter #(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        CLK_48MHZ,
    input  logic        RESET,
    input  logic        REQ0,
    input  logic        REQ1,
    input  logic        WR0,
    input  logic        WR1,
    input  logic [17:0] ADDR0,
    input  logic [17:0] ADDR1,
    input  logic [15:0] WDATA0,
    input  logic [15:0] WDATA1,
    input  logic [1:0]  BE0,
    input  logic [1:0]  BE1,
    output logic        GNT0,
    output logic        GNT1,
    output logic        DONE0,
    output logic        DONE1,
    output logic [15:0] RDATA,
    output logic [17:0] SRAM_A,
    output logic [15:0] SRAM_D_OUT,
    output logic        SRAM_D_OE,
    input  logic [15:0] SRAM_D_IN,
    output logic        SRAM_CE,
    output logic        SRAM_WE,
    output logic        SRAM_OE,
    output logic [3:0]  SRAM_SRBS
);
    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic        port_q;
    logic        last_q;
    logic        wr_q;
    logic [1:0]  be_q;
    logic [17:0] addr_q;
    logic [15:0] wdata_q;
    logic [15:0] rdata_q;
    logic        gnt0_q, gnt1_q, done0_q, done1_q;
    logic        ce_q, we_q, oe_q, doe_q;
    logic [3:0]  srbs_q;
    logic        win_d;

    // On a tie the port not served last wins; otherwise the lone requester wins.
    always_comb begin
        win_d = 1'b0;
        if (REQ0 && REQ1) begin
            win_d = ~last_q;
        end else if (REQ1) begin
            win_d = 1'b1;
        end
    end

    always_ff @(posedge CLK_48MHZ) begin
        if (RESET) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            port_q  <= 1'b0;
            last_q  <= 1'b1;
            wr_q    <= 1'b0;
            be_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            ce_q    <= 1'b1;
            we_q    <= 1'b1;
            oe_q    <= 1'b1;
            doe_q   <= 1'b0;
            srbs_q  <= '1;
        end else begin
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    ce_q   <= 1'b1;
                    we_q   <= 1'b1;
                    oe_q   <= 1'b1;
                    doe_q  <= 1'b0;
                    srbs_q <= '1;
                    if (REQ0 || REQ1) begin
                        gnt0_q  <= ~win_d;
                        gnt1_q  <= win_d;
                        port_q  <= win_d;
                        last_q  <= win_d;
                        wr_q    <= win_d ? WR1 : WR0;
                        addr_q  <= win_d ? ADDR1 : ADDR0;
                        wdata_q <= win_d ? WDATA1 : WDATA0;
                        be_q    <= win_d ? BE1 : BE0;
                        cnt_q   <= 4'(WAIT_CYCLES);
                        state_q <= SETUP;
                    end
                end
                SETUP: begin
                    ce_q    <= 1'b0;
                    srbs_q  <= {2'b11, ~be_q};
                    doe_q   <= wr_q;
                    state_q <= STROBE;
                end
                STROBE: begin
                    we_q  <= ~wr_q;
                    oe_q  <= wr_q;
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_q <= HOLD;
                    end
                end
                HOLD: begin
                    // OE is still low during this cycle, so the pad data is sampled here.
                    ce_q    <= 1'b1;
                    we_q    <= 1'b1;
                    oe_q    <= 1'b1;
                    srbs_q  <= '1;
                    done0_q <= ~port_q;
                    done1_q <= port_q;
                    if (!wr_q) begin
                        rdata_q <= SRAM_D_IN;
                    end
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign GNT0       = gnt0_q;
    assign GNT1       = gnt1_q;
    assign DONE0      = done0_q;
    assign DONE1      = done1_q;
    assign RDATA      = rdata_q;
    assign SRAM_A     = addr_q;
    assign SRAM_D_OUT = wdata_q;
    assign SRAM_D_OE  = doe_q;
    assign SRAM_CE    = ce_q;
    assign SRAM_WE    = we_q;
    assign SRAM_OE    = oe_q;
    assign SRAM_SRBS  = srbs_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: behavioural SRAM pad, phase-based reference model with a
// per-cycle compare, and directed accesses with hand-computed expectations.
module tb_sram_arbiter;
    localparam int W = 2;

    logic clk = 1'b0;
    initial forever #5 clk = ~clk;

    logic        rst;
    logic        req0, req1, wr0, wr1;
    logic [17:0] addr0, addr1;
    logic [15:0] wdata0, wdata1;
    logic [1:0]  be0, be1;
    logic        gnt0, gnt1, done0, done1;
    logic [15:0] rdata, d_out, d_in;
    logic [17:0] sram_a;
    logic        d_oe, ce, we, oe;
    logic [3:0]  srbs;

    logic        req5;
    logic        gnt05, gnt15, done05, done15, d_oe5, ce5, we5, oe5;
    logic [15:0] rdata5, d_out5, d_in5;
    logic [17:0] sram_a5;
    logic [3:0]  srbs5;

    sram_arbiter #(.WAIT_CYCLES(W)) dut (
        .CLK_48MHZ(clk), .RESET(rst),
        .REQ0(req0), .REQ1(req1), .WR0(wr0), .WR1(wr1),
        .ADDR0(addr0), .ADDR1(addr1), .WDATA0(wdata0), .WDATA1(wdata1),
        .BE0(be0), .BE1(be1), .GNT0(gnt0), .GNT1(gnt1),
        .DONE0(done0), .DONE1(done1), .RDATA(rdata),
        .SRAM_A(sram_a), .SRAM_D_OUT(d_out), .SRAM_D_OE(d_oe), .SRAM_D_IN(d_in),
        .SRAM_CE(ce), .SRAM_WE(we), .SRAM_OE(oe), .SRAM_SRBS(srbs)
    );

    sram_arbiter #(.WAIT_CYCLES(5)) dut5 (
        .CLK_48MHZ(clk), .RESET(rst),
        .REQ0(1'b0), .REQ1(req5), .WR0(1'b0), .WR1(1'b0),
        .ADDR0(18'h0), .ADDR1(18'h00042), .WDATA0(16'h0), .WDATA1(16'h0),
        .BE0(2'b00), .BE1(2'b11), .GNT0(gnt05), .GNT1(gnt15),
        .DONE0(done05), .DONE1(done15), .RDATA(rdata5),
        .SRAM_A(sram_a5), .SRAM_D_OUT(d_out5), .SRAM_D_OE(d_oe5), .SRAM_D_IN(d_in5),
        .SRAM_CE(ce5), .SRAM_WE(we5), .SRAM_OE(oe5), .SRAM_SRBS(srbs5)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [15:0] dflt(input logic [17:0] a);
        return a[15:0] ^ 16'h3C3C;
    endfunction

    // Asynchronous SRAM pad: writes while CE and WE are low, drives data while CE and OE are low.
    logic [15:0] pmem [logic [17:0]];
    always @(negedge clk) begin
        logic [15:0] cur;
        if (!ce && !we) begin
            cur = pmem.exists(sram_a) ? pmem[sram_a] : dflt(sram_a);
            if (!srbs[0]) cur[7:0]  = d_out[7:0];
            if (!srbs[1]) cur[15:8] = d_out[15:8];
            pmem[sram_a] = cur;
        end
        d_in  = (!ce && !oe) ? (pmem.exists(sram_a) ? pmem[sram_a] : dflt(sram_a)) : 16'h0000;
        d_in5 = (!ce5 && !oe5) ? 16'h5A5A : 16'h0000;
    end

    // Reference model: ph is the number of cycles since the grant of the current access (-1 = none).
    int          ph = -1;
    logic        m_valid = 1'b0;
    logic        m_port = 1'b0, m_last = 1'b1, m_wr = 1'b0;
    logic [17:0] m_addr = '0;
    logic [15:0] m_data = '0, m_rdata = '0;
    logic [1:0]  m_be = '0;
    logic [15:0] smem [logic [17:0]];

    always @(posedge clk) begin
        logic [15:0] cur;
        if (rst) begin
            ph = -1; m_last = 1'b1; m_wr = 1'b0; m_addr = '0; m_data = '0;
            m_rdata = '0; m_be = '0; m_valid = 1'b1;
        end else if (m_valid) begin
            if (ph >= 0 && ph < W + 2) begin
                ph++;
            end else if (req0 || req1) begin
                m_port = (req0 && req1) ? ~m_last : req1;
                m_last = m_port;
                m_wr   = m_port ? wr1 : wr0;
                m_addr = m_port ? addr1 : addr0;
                m_data = m_port ? wdata1 : wdata0;
                m_be   = m_port ? be1 : be0;
                ph = 0;
            end else begin
                ph = -1;
            end
            if (ph == W + 2) begin
                cur = smem.exists(m_addr) ? smem[m_addr] : dflt(m_addr);
                if (m_wr) begin
                    if (m_be[0]) cur[7:0]  = m_data[7:0];
                    if (m_be[1]) cur[15:8] = m_data[15:8];
                    smem[m_addr] = cur;
                end else begin
                    m_rdata = cur;
                end
            end
        end
    end

    always @(negedge clk) begin
        bit act, strb;
        if (m_valid) begin
            act  = (ph >= 1) && (ph <= W + 1);
            strb = (ph >= 2) && (ph <= W + 1);
            chk("gnt0",  32'(gnt0),  32'(ph == 0 && !m_port));
            chk("gnt1",  32'(gnt1),  32'(ph == 0 && m_port));
            chk("done0", 32'(done0), 32'(ph == W + 2 && !m_port));
            chk("done1", 32'(done1), 32'(ph == W + 2 && m_port));
            chk("ce",    32'(ce),    32'(!act));
            chk("we",    32'(we),    32'(!(m_wr && strb)));
            chk("oe",    32'(oe),    32'(!(!m_wr && strb)));
            chk("d_oe",  32'(d_oe),  32'(m_wr && ph >= 1 && ph <= W + 2));
            chk("srbs",  32'(srbs),  32'(act ? {2'b11, ~m_be} : 4'hF));
            chk("addr",  32'(sram_a), 32'(m_addr));
            chk("d_out", 32'(d_out), 32'(m_data));
            chk("rdata", 32'(rdata), 32'(m_rdata));
            chk("inv_doe_oe", 32'(d_oe && !oe), 32'(0));
            chk("inv_we_oe",  32'(!we && !oe), 32'(0));
        end
    end

    int          tG, t_we, t_oe, t_doe, t_done, t_ce;
    logic [3:0]  t_srbs2;
    logic [17:0] t_a0;
    logic [15:0] t_rd;

    task automatic access(input bit p, input bit w, input logic [17:0] a,
                          input logic [15:0] d, input logic [1:0] b);
        int n;
        if (!p) begin req0 = 1; wr0 = w; addr0 = a; wdata0 = d; be0 = b; end
        else    begin req1 = 1; wr1 = w; addr1 = a; wdata1 = d; be1 = b; end
        n = 0;
        do begin @(negedge clk); n++; end while (!(p ? gnt1 : gnt0) && n < 40);
        chk("gnt_wait", 32'(p ? gnt1 : gnt0), 32'(1));
        req0 = 0; req1 = 0;
        tG = cyc; t_a0 = sram_a;
        t_we = 0; t_oe = 0; t_doe = 0; t_done = 0; t_ce = 0; t_srbs2 = '0; t_rd = '0;
        for (int k = 0; k <= W + 3; k++) begin
            if (k > 0) @(negedge clk);
            if (!we) t_we |= 1 << k;
            if (!oe) t_oe |= 1 << k;
            if (d_oe) t_doe |= 1 << k;
            if (!ce) t_ce |= 1 << k;
            if (p ? done1 : done0) t_done |= 1 << k;
            if (k == 2) t_srbs2 = srbs;
            if (k == W + 2) t_rd = rdata;
        end
    endtask

    initial begin
        int n, cnt;
        int gp[$];
        int gc[$];
        rst = 1; req0 = 0; req1 = 0; wr0 = 0; wr1 = 0; addr0 = '0; addr1 = '0;
        wdata0 = '0; wdata1 = '0; be0 = '0; be1 = '0; req5 = 0;
        pmem[18'h00010] = 16'hBEEF;
        smem[18'h00010] = 16'hBEEF;
        repeat (3) @(negedge clk);
        chk("rst_ce", 32'(ce), 32'(1));
        chk("rst_srbs", 32'(srbs), 32'(4'hF));
        chk("rst_doe", 32'(d_oe), 32'(0));
        chk("rst_rdata", 32'(rdata), 32'(0));
        rst = 0;
        @(negedge clk);

        access(0, 1, 18'h12345, 16'hA55A, 2'b11);
        chk("wr_addr", 32'(t_a0), 32'h12345);
        chk("wr_we_mask", 32'(t_we), 32'h0C);
        chk("wr_doe_mask", 32'(t_doe), 32'h1E);
        chk("wr_ce_mask", 32'(t_ce), 32'h0E);
        chk("wr_done_mask", 32'(t_done), 32'h10);
        chk("wr_srbs", 32'(t_srbs2), 32'hC);

        access(1, 0, 18'h00010, 16'h0, 2'b11);
        chk("rd_oe_mask", 32'(t_oe), 32'h0C);
        chk("rd_doe_mask", 32'(t_doe), 32'h0);
        chk("rd_done_mask", 32'(t_done), 32'h10);
        chk("rd_data", 32'(t_rd), 32'hBEEF);

        // Both requesters held: alternating grants every 3+W cycles.
        req0 = 1; wr0 = 1; addr0 = 18'h00100; wdata0 = 16'h1111; be0 = 2'b11;
        req1 = 1; wr1 = 0; addr1 = 18'h12345; be1 = 2'b11;
        n = 0;
        while (gp.size() < 4 && n < 60) begin
            @(negedge clk); n++;
            if (gnt0) begin gp.push_back(0); gc.push_back(cyc); end
            if (gnt1) begin gp.push_back(1); gc.push_back(cyc); end
        end
        req0 = 0; req1 = 0;
        chk("tie_count", 32'(gp.size()), 32'd4);
        for (int i = 0; i < gp.size() && i < 4; i++) begin
            chk("tie_order", 32'(gp[i]), 32'(i % 2));
            if (i > 0) chk("tie_spacing", 32'(gc[i] - gc[i-1]), 32'd5);
        end
        repeat (8) @(negedge clk);
        chk("tie_rdata", 32'(rdata), 32'hA55A);

        access(0, 1, 18'h12345, 16'h1234, 2'b10);
        chk("be10_srbs", 32'(t_srbs2), 32'hD);
        access(1, 0, 18'h12345, 16'h0, 2'b11);
        chk("be10_readback", 32'(t_rd), 32'h125A);
        access(0, 1, 18'h12345, 16'hFFFF, 2'b00);
        chk("be00_srbs", 32'(t_srbs2), 32'hF);
        chk("be00_done", 32'(t_done), 32'h10);
        chk("be00_we_mask", 32'(t_we), 32'h0C);
        access(1, 0, 18'h12345, 16'h0, 2'b11);
        chk("be00_readback", 32'(t_rd), 32'h125A);

        access(0, 1, 18'h3FFFF, 16'h7E57, 2'b11);
        chk("top_addr", 32'(t_a0), 32'h3FFFF);
        access(1, 0, 18'h3FFFF, 16'h0, 2'b11);
        chk("top_readback", 32'(t_rd), 32'h7E57);

        // REQ0 raised while busy and withdrawn before it could be granted.
        req1 = 1; wr1 = 0; addr1 = 18'h00010; be1 = 2'b11;
        n = 0;
        do begin @(negedge clk); n++; end while (!gnt1 && n < 40);
        req1 = 0; req0 = 1; wr0 = 1; addr0 = 18'h00300; wdata0 = 16'hDEAD; be0 = 2'b11;
        repeat (2) @(negedge clk);
        req0 = 0;
        cnt = 0;
        repeat (10) begin @(negedge clk); if (gnt0) cnt++; end
        chk("withdrawn_gnt0", 32'(cnt), 32'd0);

        // Reset during the strobe of a write.
        req0 = 1; wr0 = 1; addr0 = 18'h00200; wdata0 = 16'h0BAD; be0 = 2'b11;
        n = 0;
        do begin @(negedge clk); n++; end while (!gnt0 && n < 40);
        req0 = 0;
        repeat (2) @(negedge clk);
        chk("abort_we_low", 32'(we), 32'(0));
        rst = 1;
        req0 = 1; wr0 = 0; addr0 = 18'h00010; be0 = 2'b11;
        req1 = 1; wr1 = 0; addr1 = 18'h00010; be1 = 2'b11;
        @(negedge clk);
        chk("abort_ctl", 32'({ce, we, oe, d_oe, done0}), 32'(5'b11100));
        rst = 0;
        n = 0; cnt = 0;
        do begin
            @(negedge clk); n++;
            if (done0) cnt++;
        end while (!gnt0 && !gnt1 && n < 40);
        chk("abort_no_done0", 32'(cnt), 32'd0);
        chk("post_rst_first_gnt0", 32'({gnt0, gnt1}), 32'(2'b10));
        req0 = 0;
        n = 0;
        do begin @(negedge clk); n++; end while (!gnt1 && n < 40);
        req1 = 0;
        chk("post_rst_gnt1", 32'(gnt1), 32'(1));
        repeat (8) @(negedge clk);

        // WAIT_CYCLES=5 instance: read strobe length and latency.
        req5 = 1;
        n = 0;
        do begin @(negedge clk); n++; end while (!gnt15 && n < 40);
        req5 = 0;
        t_oe = 0; t_done = 0; t_rd = '0;
        for (int k = 0; k < 10; k++) begin
            if (k > 0) @(negedge clk);
            if (!oe5) t_oe |= 1 << k;
            if (done15) begin t_done |= 1 << k; t_rd = rdata5; end
        end
        chk("w5_oe_mask", 32'(t_oe), 32'h7C);
        chk("w5_done_mask", 32'(t_done), 32'h80);
        chk("w5_rdata", 32'(t_rd), 32'h5A5A);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
